pc_sequencer: RTL and testbench

Next-PC controller for the fetch stage of the five-stage pipeline. Selects the next program counter each cycle from sequential, branch, jump and (optionally) exception sources; holds the PC on hazard-unit stalls; and issues IF/ID flush bubbles after every redirect. Owns the PC register contents and the instruction-memory fetch address, and replaces the free-running PC-plus-4 loop around the PC register.

---
 rtl/pc_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Next-PC controller for the fetch stage. It owns the PC register and picks the
// next fetch address on every falling clock edge. The sources, from highest to
// lowest priority, are:
//   - exception (optional)
//   - jump
//   - taken branch
//   - stall (hold)
//   - sequential pc + 4
// After each redirect it issues REDIRECT_BUBBLES cycles of IF/ID flush.
//
// Optional feature:
//   PC_SEQ_EXC_EN - when defined, adds the exc_req port. An exception request
//                   redirects to EXC_VECTOR with top priority. When undefined,
//                   the exception source is tied off and EXC_VECTOR has no
//                   effect.
//
// Parameters:
//   RESET_VECTOR      PC value loaded by reset
//   EXC_VECTOR        exception handler address
//   REDIRECT_BUBBLES  flush cycles after a redirect (1..3)
//
// Ports:
//   clk            pipeline clock; all state changes on its falling edge
//   reset          asynchronous, active-high
//   stall          hazard-unit hold request
//   branch_taken   branch resolved taken; branch_target is its destination
//   jump           jump request; jump_target is its destination
//   exc_req        exception request (PC_SEQ_EXC_EN only)
//   pc             current fetch address
//   pc_plus4       pc + 4, combinational
//   fetch_valid    fetched instruction is to be used
//   flush_ifid     squash IF/ID register contents
//   misalign       one-cycle pulse: redirect target had bits [1:0] != 0
//   seq_state      FSM state (BOOT=0, RUN=1, HOLD=2, FLUSH=3), for debug
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR       = 32'h0000_0180,
   parameter int unsigned REDIRECT_BUBBLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
`ifdef PC_SEQ_EXC_EN
   input  logic        exc_req,
`endif
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        flush_ifid,
   output logic        misalign,
   output logic [1:0]  seq_state
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam logic [1:0] BUBBLES = REDIRECT_BUBBLES[1:0];

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic        flush_ifid_q, flush_ifid_d;
   logic        misalign_q, misalign_d;
   logic [1:0]  bubble_cnt_q, bubble_cnt_d;

   logic        exc_s;
   logic        redirect_s;
   logic [31:0] target_s;

   // Without the exception feature the source is tied low, so the shared
   // priority mux reduces to jump > branch.
`ifdef PC_SEQ_EXC_EN
   assign exc_s = exc_req;
`else
   assign exc_s = 1'b0;
`endif

   // Redirect request and its target, in priority order.
   always_comb begin
      redirect_s = exc_s | jump | branch_taken;
      if (exc_s) begin
         target_s = EXC_VECTOR;
      end else if (jump) begin
         target_s = jump_target;
      end else begin
         target_s = branch_target;
      end
   end

   // Next-state and next-output computation.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_valid_d = 1'b0;
      flush_ifid_d  = 1'b0;
      misalign_d    = 1'b0;
      bubble_cnt_d  = bubble_cnt_q;
      case (state_q)
         BOOT: begin
            // Single settling cycle: requests, including stall, are ignored.
            state_d = RUN;
         end
         RUN, HOLD, FLUSH: begin
            if (redirect_s) begin
               // Redirect beats stall. The target is word-aligned by force and
               // the dropped low bits are reported.
               pc_d         = {target_s[31:2], 2'b00};
               misalign_d   = |target_s[1:0];
               bubble_cnt_d = BUBBLES;
               flush_ifid_d = 1'b1;
               state_d      = FLUSH;
            end else if (state_q == FLUSH) begin
               bubble_cnt_d = bubble_cnt_q - 2'd1;
               if (stall) begin
                  pc_d = pc_q;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
               // On the last bubble, fall into HOLD or RUN depending on stall.
               if (bubble_cnt_q == 2'd1) begin
                  if (stall) begin
                     state_d = HOLD;
                  end else begin
                     state_d       = RUN;
                     fetch_valid_d = 1'b1;
                  end
               end else begin
                  flush_ifid_d = 1'b1;
               end
            end else if (stall) begin
               state_d = HOLD;
            end else begin
               // Also the HOLD exit: pc advances on the edge stall drops.
               state_d       = RUN;
               pc_d          = pc_q + 32'd4;
               fetch_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State and registered outputs; updates on the falling edge.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= BOOT;
         pc_q          <= RESET_VECTOR;
         fetch_valid_q <= 1'b0;
         flush_ifid_q  <= 1'b0;
         misalign_q    <= 1'b0;
         bubble_cnt_q  <= 2'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_valid_q <= fetch_valid_d;
         flush_ifid_q  <= flush_ifid_d;
         misalign_q    <= misalign_d;
         bubble_cnt_q  <= bubble_cnt_d;
      end
   end

   assign pc          = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign fetch_valid = fetch_valid_q;
   assign flush_ifid  = flush_ifid_q;
   assign misalign    = misalign_q;
   assign seq_state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Scoreboard bench for pc_sequencer. Inputs change on the rising edge. Each
// expected output set is queued when its stimulus is driven. It is popped and
// compared #1 after the falling edge that the DUT acts on.
//   dut1 uses REDIRECT_BUBBLES=1.
//   dut3 uses REDIRECT_BUBBLES=3, has its own reset, and is used for the
//   long-flush and mid-flush reset scenario.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        fv;
      logic        fl;
      logic        mis;
      logic [1:0]  st;
   } obs_t;

   typedef struct packed {
      logic        stall;
      logic        br;
      logic [31:0] bt;
      logic        j;
      logic [31:0] jt;
      logic        exc;
      obs_t        exp;
   } step_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reset3 = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'h0;
   logic        exc_req = 1'b0;

   logic [31:0] pc1, pc41, pc3, pc43;
   logic        fv1, fl1, mis1, fv3, fl3, mis3;
   logic [1:0]  st1, st3;

   int   n_checks = 0;
   int   n_fails  = 0;
   obs_t exp_q[$];

   always #5 clk = ~clk;

   pc_sequencer #(.REDIRECT_BUBBLES(1)) dut1 (
      .clk(clk), .reset(reset), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
`ifdef PC_SEQ_EXC_EN
      .exc_req(exc_req),
`endif
      .pc(pc1), .pc_plus4(pc41), .fetch_valid(fv1), .flush_ifid(fl1),
      .misalign(mis1), .seq_state(st1)
   );

   pc_sequencer #(.REDIRECT_BUBBLES(3)) dut3 (
      .clk(clk), .reset(reset3), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
`ifdef PC_SEQ_EXC_EN
      .exc_req(exc_req),
`endif
      .pc(pc3), .pc_plus4(pc43), .fetch_valid(fv3), .flush_ifid(fl3),
      .misalign(mis3), .seq_state(st3)
   );

   function automatic obs_t mk(logic [31:0] p, logic fv, logic fl, logic mis, logic [1:0] st);
      return {p, p + 32'd4, fv, fl, mis, st};
   endfunction

   function automatic step_t stp(logic s, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                                 logic x, obs_t e);
      return {s, b, bt, j, jt, x, e};
   endfunction

   function automatic obs_t obs1();
      return {pc1, pc41, fv1, fl1, mis1, st1};
   endfunction

   function automatic obs_t obs3();
      return {pc3, pc43, fv3, fl3, mis3, st3};
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("pc=%h pc4=%h fv=%b fl=%b mis=%b st=%0d", o.pc, o.pc4, o.fv, o.fl, o.mis, o.st);
   endfunction

   task automatic drive(step_t s);
      stall         = s.stall;
      branch_taken  = s.br;
      branch_target = s.bt;
      jump          = s.j;
      jump_target   = s.jt;
      exc_req       = s.exc;
   endtask

   task automatic test_reset();
      obs_t e, g;
      #2;
      exp_q.push_back(mk(32'h0, 1'b0, 1'b0, 1'b0, S_BOOT));
      e = exp_q.pop_front();
      g = obs1();
      n_checks++;
      if (g !== e) begin
         n_fails++;
         $display("FAIL reset: got %s, expected %s", fmt(g), fmt(e));
      end
   endtask

   task automatic test_boot();
      step_t q[$];
      obs_t  e, g;
      // stall during the BOOT edge must be ignored
      q.push_back(stp(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(32'h0, 1'b0, 1'b0, 1'b0, S_RUN)));
      q.push_back(stp(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(32'h4, 1'b1, 1'b0, 1'b0, S_RUN)));
      q.push_back(stp(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(32'h8, 1'b1, 1'b0, 1'b0, S_RUN)));
      q.push_back(stp(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(32'hC, 1'b1, 1'b0, 1'b0, S_RUN)));
      @(negedge clk);
      #1 reset = 1'b0;
      foreach (q[i]) begin
         @(posedge clk);
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         #1;
         e = exp_q.pop_front();
         g = obs1();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL boot[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
      end
   endtask

   task automatic test_branch();
      step_t q[$];
      obs_t  e, g;
      q.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h10, 1'b1, 1'b0, 1'b0, S_RUN)));
      q.push_back(stp(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, mk(32'h40, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h44, 1'b1, 1'b0, 1'b0, S_RUN)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h48, 1'b1, 1'b0, 1'b0, S_RUN)));
      foreach (q[i]) begin
         @(posedge clk);
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         #1;
         e = exp_q.pop_front();
         g = obs1();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL branch[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
      end
   endtask

   task automatic test_stall();
      step_t q[$];
      obs_t  e, g;
      q.push_back(stp(1'b0, 1'b1, 32'h1C, 1'b0, 32'h0, 1'b0, mk(32'h1C, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h20, 1'b1, 1'b0, 1'b0, S_RUN)));
      for (int k = 0; k < 3; k++)
         q.push_back(stp(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mk(32'h20, 1'b0, 1'b0, 1'b0, S_HOLD)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h24, 1'b1, 1'b0, 1'b0, S_RUN)));
      foreach (q[i]) begin
         @(posedge clk);
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         #1;
         e = exp_q.pop_front();
         g = obs1();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL stall[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
      end
   endtask

   task automatic test_priority();
      step_t q[$];
      obs_t  e, g;
      q.push_back(stp(1'b1, 1'b1, 32'h200, 1'b1, 32'h100, 1'b0, mk(32'h100, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, mk(32'h104, 1'b1, 1'b0, 1'b0, S_RUN)));
      q.push_back(stp(1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, mk(32'h200, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, mk(32'h204, 1'b1, 1'b0, 1'b0, S_RUN)));
`ifdef PC_SEQ_EXC_EN
      q.push_back(stp(1'b1, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, mk(32'h180, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, mk(32'h184, 1'b1, 1'b0, 1'b0, S_RUN)));
`endif
      foreach (q[i]) begin
         @(posedge clk);
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         #1;
         e = exp_q.pop_front();
         g = obs1();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL priority[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
      end
   endtask

   task automatic test_misalign();
      step_t q[$];
      obs_t  e, g;
      q.push_back(stp(1'b0, 1'b0, 32'h0,   1'b1, 32'h103, 1'b0, mk(32'h100, 1'b0, 1'b1, 1'b1, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, mk(32'h104, 1'b1, 1'b0, 1'b0, S_RUN)));
      q.push_back(stp(1'b0, 1'b1, 32'h206, 1'b0, 32'h0,   1'b0, mk(32'h204, 1'b0, 1'b1, 1'b1, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, mk(32'h208, 1'b1, 1'b0, 1'b0, S_RUN)));
      foreach (q[i]) begin
         @(posedge clk);
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         #1;
         e = exp_q.pop_front();
         g = obs1();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL misalign[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t q[$];
      obs_t  e, g;
      q.push_back(stp(1'b0, 1'b1, 32'h300, 1'b0, 32'h0,   1'b0, mk(32'h300, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      // redirect while flushing restarts the flush
      q.push_back(stp(1'b0, 1'b0, 32'h0,   1'b1, 32'h402, 1'b0, mk(32'h400, 1'b0, 1'b1, 1'b1, S_FLUSH)));
      // stall on the last bubble lands in HOLD with pc held
      q.push_back(stp(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, mk(32'h400, 1'b0, 1'b0, 1'b0, S_HOLD)));
      // redirect out of HOLD overrides the held stall
      q.push_back(stp(1'b1, 1'b1, 32'h500, 1'b0, 32'h0,   1'b0, mk(32'h500, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, mk(32'h504, 1'b1, 1'b0, 1'b0, S_RUN)));
      foreach (q[i]) begin
         @(posedge clk);
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         #1;
         e = exp_q.pop_front();
         g = obs1();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL back_to_back[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
      end
   endtask

   task automatic test_wrap();
      step_t q[$];
      obs_t  e, g;
      q.push_back(stp(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0, mk(32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, mk(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, S_RUN)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0, S_RUN)));
      foreach (q[i]) begin
         @(posedge clk);
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         #1;
         e = exp_q.pop_front();
         g = obs1();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL wrap[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
      end
   endtask

   task automatic test_flush_reset();
      step_t q[$];
      step_t r[$];
      obs_t  e, g;
      q.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h0,  1'b0, 1'b0, 1'b0, S_RUN)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h4,  1'b1, 1'b0, 1'b0, S_RUN)));
      q.push_back(stp(1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, mk(32'h80, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h84, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h88, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h8C, 1'b1, 1'b0, 1'b0, S_RUN)));
      q.push_back(stp(1'b0, 1'b1, 32'hC0, 1'b0, 32'h0, 1'b0, mk(32'hC0, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      q.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'hC4, 1'b0, 1'b1, 1'b0, S_FLUSH)));
      r.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h0,  1'b0, 1'b0, 1'b0, S_RUN)));
      r.push_back(stp(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, mk(32'h4,  1'b1, 1'b0, 1'b0, S_RUN)));
      @(negedge clk);
      #1 reset3 = 1'b0;
      foreach (q[i]) begin
         @(posedge clk);
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         #1;
         e = exp_q.pop_front();
         g = obs3();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL flush3[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
      end
      // mid-flush reset, asserted away from any falling edge
      @(posedge clk);
      #1 reset3 = 1'b1;
      exp_q.push_back(mk(32'h0, 1'b0, 1'b0, 1'b0, S_BOOT));
      #1;
      e = exp_q.pop_front();
      g = obs3();
      n_checks++;
      if (g !== e) begin
         n_fails++;
         $display("FAIL async_reset: got %s, expected %s", fmt(g), fmt(e));
      end
      exp_q.push_back(mk(32'h0, 1'b0, 1'b0, 1'b0, S_BOOT));
      @(negedge clk);
      #1;
      e = exp_q.pop_front();
      g = obs3();
      n_checks++;
      if (g !== e) begin
         n_fails++;
         $display("FAIL reset_hold: got %s, expected %s", fmt(g), fmt(e));
      end
      reset3 = 1'b0;
      foreach (r[i]) begin
         @(posedge clk);
         drive(r[i]);
         exp_q.push_back(r[i].exp);
         @(negedge clk);
         #1;
         e = exp_q.pop_front();
         g = obs3();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL post_reset[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d failures so far", n_fails);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_boot();
      test_branch();
      test_stall();
      test_priority();
      test_misalign();
      test_back_to_back();
      test_wrap();
      test_flush_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
